tlb_lookup_arbiter: RTL and testbench
=====================================

# tlb_lookup_arbiter

Shares the single combinational TLB translation datapath between three requesters: instruction fetch (I), data memory access (D), and the CP0 TLBP probe (P). Handles valid/ready handshakes, sequences each lookup through a registered address stage, and classifies unmapped kseg0/kseg1 addresses. Returns a registered physical address, cacheability and MIPS exception class to the winning requester. Sits in the MMU between the pipeline/CP0 and the TLB translator.

## Interface
- No parameters.
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- i_req_valid / i_req_ready  in/out  1  fetch request handshake
- i_vaddr  in  32  fetch virtual address
- d_req_valid / d_req_ready  in/out  1  data request handshake
- d_vaddr  in  32  data virtual address
- d_is_store  in  1  data request is a store
- p_req_valid / p_req_ready  in/out  1  TLBP probe handshake
- p_vaddr  in  32  EntryHi VPN2 as an address
- p_asid  in  8  EntryHi ASID
- asid  in  8  current ASID for I/D lookups
- tlb_wr  in  1  CP0 is writing a TLB entry this cycle
- tlb_vaddr / tlb_asid  out  32/8  drive to translator
- tlb_paddr  in  32  translator physical address
- tlb_miss, tlb_valid, tlb_dirty, tlb_uncached  in  1 each  translator flags
- tlb_index  in  4  translator match index
- i_rsp_valid, d_rsp_valid  out  1  one-cycle response strobes
- i_rsp_paddr, d_rsp_paddr  out  32  physical address
- i_rsp_uncached, d_rsp_uncached  out  1  bypass cache
- i_rsp_exc, d_rsp_exc  out  2  0 none, 1 refill, 2 invalid, 3 modified (D only)
- p_rsp_valid  out  1  probe response strobe
- p_rsp_miss  out  1  probe missed
- p_rsp_index  out  4  matching index

## Operation
- FSM states: IDLE, LOOKUP, RESP.
- Ready is combinational and asserted only to the granted requester, only in IDLE or RESP, and only with tlb_wr low. All readies are 0 while rst_n is low.
- Grant order: P > D > I (fixed priority; round-robin variant under Configuration).
- On accept: capture the owner, vaddr, store flag and ASID (p_asid for P, otherwise asid), then go to LOOKUP. Requesters hold valid and operands stable until ready.
- LOOKUP: tlb_vaddr and tlb_asid are driven from registers.
  - If tlb_wr is high, remain in LOOKUP and capture nothing.
  - Otherwise, latch the result into the owner's response registers and go to RESP.
- RESP: the owner's rsp_valid is high for one cycle. A new accept in this cycle goes to LOOKUP; no accept goes to IDLE.
- Classification for I/D, by vaddr[31:29]:
  - 100 (kseg0): paddr = vaddr & 0x1FFF_FFFF, cached, exc 0.
  - 101 (kseg1): same paddr, uncached, exc 0.
  - Any other segment is mapped:
    - tlb_miss → exc 1.
    - Else !tlb_valid → exc 2.
    - Else D store with !tlb_dirty → exc 3.
    - Else exc 0, paddr = tlb_paddr, uncached = tlb_uncached.
- With exc ≠ 0, paddr holds the vaddr so the pipeline can report BadVAddr.
- Probe: p_rsp_miss = tlb_miss, p_rsp_index = tlb_index (0 on miss). No segment check.
- Response data registers hold their value until the next response for the same requester.

## Timing
- Reset: state IDLE; all rsp_valid 0; all rsp data, tlb_vaddr and tlb_asid 0; RR pointer set to I.
- Latency: accept at cycle N → rsp_valid at N+2. Each extra cycle of tlb_wr during LOOKUP adds one cycle.
- Throughput: one lookup per 2 cycles.
- Simultaneous requests: one grant per accept cycle. Losers see ready low and hold.
- Reset mid-lookup: the request is dropped, no response is produced, and the requester re-issues.

## Configuration
- TLB_ARB_RR_EN defined:
  - Arbitration between I and D alternates, starting from the pointer.
  - After each accepted I or D request, the pointer moves to the other requester.
  - P keeps absolute priority.
- Not defined: fixed P > D > I.

## Structure
- Package tlb_arb_pkg holds:
  - FSM state encoding;
  - exception codes (EXC_NONE/REFILL/INVALID/MOD);
  - owner codes (OWN_I/D/P);
  - segment constants (SEG_KSEG0 = 3'b100, SEG_KSEG1 = 3'b101, PHYS_MASK = 32'h1FFF_FFFF).
- One sub-module, tlb_arb_grant: pure combinational grant logic (inputs: three valids, RR pointer; output: one-hot grant). Contains the TLB_ARB_RR_EN selection.

## Test plan
- I request vaddr 0x0040_1234 (mapped), translator returns paddr 0x0123_4234, valid=1 → i_rsp_valid at N+2, exc 0, paddr 0x0123_4234.
- D store to 0x7FFF_0010 with tlb_valid=1, tlb_dirty=0 → d_rsp_exc=3, d_rsp_paddr=0x7FFF_0010. D load to the same address → exc 0.
- D load 0xA000_1000 → paddr 0x0000_1000, uncached=1, exc 0. With tlb_miss=1 at the same address → still exc 0, since kseg1 is unmapped.
- P, D and I all valid in the same cycle → P granted first, then D, then I. Under TLB_ARB_RR_EN with D and I held continuously, grants alternate D, I, D, I.
- tlb_wr held for 2 cycles during LOOKUP → response delayed to N+4 and reflects the translator output after the write.
- Assert rst_n low during LOOKUP → no rsp_valid afterwards, all outputs return to 0, and the next request completes normally.

Source files
------------

// File: rtl/tlb_arb_pkg.sv
// rtl/tlb_arb_pkg.sv - shared types and constants for the TLB lookup arbiter
package tlb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_I = 2'd0,
    OWN_D = 2'd1,
    OWN_P = 2'd2
  } owner_t;

  localparam logic [1:0] EXC_NONE    = 2'd0;
  localparam logic [1:0] EXC_REFILL  = 2'd1;
  localparam logic [1:0] EXC_INVALID = 2'd2;
  localparam logic [1:0] EXC_MOD     = 2'd3;

  localparam logic [2:0]  SEG_KSEG0 = 3'b100;
  localparam logic [2:0]  SEG_KSEG1 = 3'b101;
  localparam logic [31:0] PHYS_MASK = 32'h1FFF_FFFF;

  // Bit positions inside the one-hot grant vector
  localparam int GNT_I = 0;
  localparam int GNT_D = 1;
  localparam int GNT_P = 2;

  function automatic logic is_unmapped(input logic [2:0] seg);
    return (seg == SEG_KSEG0) || (seg == SEG_KSEG1);
  endfunction

endpackage

// File: rtl/tlb_arb_grant.sv
// rtl/tlb_arb_grant.sv - one-hot grant selection between probe, data and fetch (TLB_ARB_RR_EN: I/D round-robin)
module tlb_arb_grant
  import tlb_arb_pkg::*;
(
  input  logic       i_i_valid,
  input  logic       i_d_valid,
  input  logic       i_p_valid,
  input  logic       i_rr_ptr_d,
  output logic [2:0] o_grant
);

`ifdef TLB_ARB_RR_EN
  // Probe always wins; contention between I and D resolved by the pointer
  always_comb begin
    o_grant = 3'b000;
    if (i_p_valid) begin
      o_grant[GNT_P] = 1'b1;
    end else if (i_i_valid && i_d_valid) begin
      if (i_rr_ptr_d) o_grant[GNT_D] = 1'b1;
      else            o_grant[GNT_I] = 1'b1;
    end else if (i_d_valid) begin
      o_grant[GNT_D] = 1'b1;
    end else if (i_i_valid) begin
      o_grant[GNT_I] = 1'b1;
    end
  end
`else
  logic w_unused_rr_ptr;
  assign w_unused_rr_ptr = i_rr_ptr_d;

  // Fixed priority: probe, then data, then fetch
  always_comb begin
    o_grant = 3'b000;
    if (i_p_valid)      o_grant[GNT_P] = 1'b1;
    else if (i_d_valid) o_grant[GNT_D] = 1'b1;
    else if (i_i_valid) o_grant[GNT_I] = 1'b1;
  end
`endif

endmodule

// File: rtl/tlb_lookup_arbiter.sv
// rtl/tlb_lookup_arbiter.sv - shares one TLB translator between fetch, data and TLBP probe (TLB_ARB_RR_EN selects I/D round-robin)
module tlb_lookup_arbiter
  import tlb_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_vaddr,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_vaddr,
  input  logic        d_is_store,
  input  logic        p_req_valid,
  output logic        p_req_ready,
  input  logic [31:0] p_vaddr,
  input  logic [7:0]  p_asid,
  input  logic [7:0]  asid,
  input  logic        tlb_wr,
  output logic [31:0] tlb_vaddr,
  output logic [7:0]  tlb_asid,
  input  logic [31:0] tlb_paddr,
  input  logic        tlb_miss,
  input  logic        tlb_valid,
  input  logic        tlb_dirty,
  input  logic        tlb_uncached,
  input  logic [3:0]  tlb_index,
  output logic        i_rsp_valid,
  output logic [31:0] i_rsp_paddr,
  output logic        i_rsp_uncached,
  output logic [1:0]  i_rsp_exc,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_paddr,
  output logic        d_rsp_uncached,
  output logic [1:0]  d_rsp_exc,
  output logic        p_rsp_valid,
  output logic        p_rsp_miss,
  output logic [3:0]  p_rsp_index
);

  arb_state_t  r_state;
  owner_t      r_owner;
  owner_t      r_rr_ptr;
  logic [31:0] r_vaddr;
  logic        r_store;
  logic [7:0]  r_asid;

  logic [2:0]  w_grant;
  logic        w_can_accept;
  logic        w_accept;
  owner_t      w_sel_owner;
  logic [31:0] w_sel_vaddr;
  logic [2:0]  w_seg;
  logic [31:0] w_paddr;
  logic        w_uncached;
  logic [1:0]  w_exc;

  tlb_arb_grant u_grant (
    .i_i_valid  (i_req_valid),
    .i_d_valid  (d_req_valid),
    .i_p_valid  (p_req_valid),
    .i_rr_ptr_d (r_rr_ptr == OWN_D),
    .o_grant    (w_grant)
  );

  // A new lookup may start only when the datapath is free and CP0 is not rewriting the TLB
  assign w_can_accept = rst_n && !tlb_wr && ((r_state == ST_IDLE) || (r_state == ST_RESP));
  assign i_req_ready  = w_can_accept && w_grant[GNT_I];
  assign d_req_ready  = w_can_accept && w_grant[GNT_D];
  assign p_req_ready  = w_can_accept && w_grant[GNT_P];
  assign w_accept     = w_can_accept && (w_grant != 3'b000);

  assign w_sel_owner = w_grant[GNT_P] ? OWN_P : (w_grant[GNT_D] ? OWN_D : OWN_I);
  assign w_sel_vaddr = w_grant[GNT_P] ? p_vaddr : (w_grant[GNT_D] ? d_vaddr : i_vaddr);

  assign tlb_vaddr = r_vaddr;
  assign tlb_asid  = r_asid;
  assign w_seg     = r_vaddr[31:29];

  // Classify the registered address; faulting lookups return the vaddr for BadVAddr
  always_comb begin
    w_paddr    = r_vaddr;
    w_uncached = 1'b0;
    w_exc      = EXC_NONE;
    if (is_unmapped(w_seg)) begin
      w_paddr    = r_vaddr & PHYS_MASK;
      w_uncached = (w_seg == SEG_KSEG1);
    end else if (tlb_miss) begin
      w_exc = EXC_REFILL;
    end else if (!tlb_valid) begin
      w_exc = EXC_INVALID;
    end else if ((r_owner == OWN_D) && r_store && !tlb_dirty) begin
      w_exc = EXC_MOD;
    end else begin
      w_paddr    = tlb_paddr;
      w_uncached = tlb_uncached;
    end
  end

  // Lookup sequencer with registered response strobes and data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_owner        <= OWN_I;
      r_rr_ptr       <= OWN_I;
      r_vaddr        <= 32'd0;
      r_store        <= 1'b0;
      r_asid         <= 8'd0;
      i_rsp_valid    <= 1'b0;
      i_rsp_paddr    <= 32'd0;
      i_rsp_uncached <= 1'b0;
      i_rsp_exc      <= EXC_NONE;
      d_rsp_valid    <= 1'b0;
      d_rsp_paddr    <= 32'd0;
      d_rsp_uncached <= 1'b0;
      d_rsp_exc      <= EXC_NONE;
      p_rsp_valid    <= 1'b0;
      p_rsp_miss     <= 1'b0;
      p_rsp_index    <= 4'd0;
    end else begin
      i_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      p_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE, ST_RESP: begin
          if (w_accept) begin
            r_owner <= w_sel_owner;
            r_vaddr <= w_sel_vaddr;
            r_store <= w_grant[GNT_D] && d_is_store;
            r_asid  <= w_grant[GNT_P] ? p_asid : asid;
            if (w_sel_owner == OWN_I)      r_rr_ptr <= OWN_D;
            else if (w_sel_owner == OWN_D) r_rr_ptr <= OWN_I;
            r_state <= ST_LOOKUP;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_LOOKUP: begin
          if (!tlb_wr) begin
            case (r_owner)
              OWN_I: begin
                i_rsp_valid    <= 1'b1;
                i_rsp_paddr    <= w_paddr;
                i_rsp_uncached <= w_uncached;
                i_rsp_exc      <= w_exc;
              end
              OWN_D: begin
                d_rsp_valid    <= 1'b1;
                d_rsp_paddr    <= w_paddr;
                d_rsp_uncached <= w_uncached;
                d_rsp_exc      <= w_exc;
              end
              OWN_P: begin
                p_rsp_valid <= 1'b1;
                p_rsp_miss  <= tlb_miss;
                p_rsp_index <= tlb_miss ? 4'd0 : tlb_index;
              end
              default: begin
              end
            endcase
            r_state <= ST_RESP;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_lookup_arbiter.sv
// tb/tb_tlb_lookup_arbiter.sv - self-checking bench for tlb_lookup_arbiter (honours TLB_ARB_RR_EN)
module tb_tlb_lookup_arbiter;

  localparam int BI = 0;
  localparam int BD = 1;
  localparam int BP = 2;

  typedef struct packed {
    logic [31:0] paddr;
    logic        miss;
    logic        valid;
    logic        dirty;
    logic        unc;
    logic [3:0]  idx;
  } tr_t;

  logic        clk;
  logic        rst_n;
  logic        i_req_valid, i_req_ready;
  logic [31:0] i_vaddr;
  logic        d_req_valid, d_req_ready;
  logic [31:0] d_vaddr;
  logic        d_is_store;
  logic        p_req_valid, p_req_ready;
  logic [31:0] p_vaddr;
  logic [7:0]  p_asid, asid;
  logic        tlb_wr;
  logic [31:0] tlb_vaddr;
  logic [7:0]  tlb_asid;
  logic [31:0] tlb_paddr;
  logic        tlb_miss, tlb_valid, tlb_dirty, tlb_uncached;
  logic [3:0]  tlb_index;
  logic        i_rsp_valid, d_rsp_valid, p_rsp_valid;
  logic [31:0] i_rsp_paddr, d_rsp_paddr;
  logic        i_rsp_uncached, d_rsp_uncached;
  logic [1:0]  i_rsp_exc, d_rsp_exc;
  logic        p_rsp_miss;
  logic [3:0]  p_rsp_index;

  int n_pass  = 0;
  int n_total = 0;
  int m_ptr   = BI;

  tlb_lookup_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_vaddr(i_vaddr),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_vaddr(d_vaddr), .d_is_store(d_is_store),
    .p_req_valid(p_req_valid), .p_req_ready(p_req_ready), .p_vaddr(p_vaddr), .p_asid(p_asid),
    .asid(asid), .tlb_wr(tlb_wr), .tlb_vaddr(tlb_vaddr), .tlb_asid(tlb_asid),
    .tlb_paddr(tlb_paddr), .tlb_miss(tlb_miss), .tlb_valid(tlb_valid), .tlb_dirty(tlb_dirty),
    .tlb_uncached(tlb_uncached), .tlb_index(tlb_index),
    .i_rsp_valid(i_rsp_valid), .i_rsp_paddr(i_rsp_paddr), .i_rsp_uncached(i_rsp_uncached), .i_rsp_exc(i_rsp_exc),
    .d_rsp_valid(d_rsp_valid), .d_rsp_paddr(d_rsp_paddr), .d_rsp_uncached(d_rsp_uncached), .d_rsp_exc(d_rsp_exc),
    .p_rsp_valid(p_rsp_valid), .p_rsp_miss(p_rsp_miss), .p_rsp_index(p_rsp_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic tr_t mk_tr(input logic [31:0] pa, input logic mi, input logic va,
                                input logic di, input logic un, input logic [3:0] ix);
    tr_t t;
    t.paddr = pa; t.miss = mi; t.valid = va; t.dirty = di; t.unc = un; t.idx = ix;
    return t;
  endfunction

  function automatic tr_t rand_tr();
    return mk_tr($urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom), 1'($urandom), 4'($urandom));
  endfunction

  task automatic drive_tr(input tr_t t);
    tlb_paddr = t.paddr; tlb_miss = t.miss; tlb_valid = t.valid;
    tlb_dirty = t.dirty; tlb_uncached = t.unc; tlb_index = t.idx;
  endtask

  // Reference: MIPS segment rules applied to the translator's answer
  function automatic void model_rsp(input int own, input logic [31:0] va, input logic st, input tr_t t,
                                    output logic [31:0] e_paddr, output logic e_unc, output logic [1:0] e_exc,
                                    output logic e_miss, output logic [3:0] e_idx);
    int unsigned seg;
    seg     = va >> 29;
    e_paddr = va; e_unc = 1'b0; e_exc = 2'd0;
    e_miss  = t.miss;
    e_idx   = t.miss ? 4'd0 : t.idx;
    if (own != BP) begin
      if (seg == 4 || seg == 5) begin
        e_paddr = va % 32'h2000_0000;
        e_unc   = (seg == 5);
      end else if (t.miss)                        e_exc = 2'd1;
      else if (!t.valid)                          e_exc = 2'd2;
      else if (own == BD && st && !t.dirty)       e_exc = 2'd3;
      else begin
        e_paddr = t.paddr;
        e_unc   = t.unc;
      end
    end
  endfunction

  function automatic int model_winner(input bit pi, input bit pd, input bit pp);
    if (pp) return BP;
`ifdef TLB_ARB_RR_EN
    if (pi && pd) return m_ptr;
`endif
    if (pd) return BD;
    if (pi) return BI;
    return -1;
  endfunction

  function automatic void model_accept(input int w);
    if (w == BI) m_ptr = BD;
    else if (w == BD) m_ptr = BI;
  endfunction

  function automatic logic own_ready(input int own);
    case (own)
      BI:      return i_req_ready;
      BD:      return d_req_ready;
      default: return p_req_ready;
    endcase
  endfunction

  task automatic clear_valids();
    i_req_valid = 1'b0; d_req_valid = 1'b0; p_req_valid = 1'b0;
  endtask

  // One request from issue to strobe drop, with optional tlb_wr stall cycles in LOOKUP
  task automatic run_req(input int own, input logic [31:0] va, input logic st, input logic [7:0] pa,
                         input tr_t pre, input tr_t post, input int wr_cyc, input string name);
    logic [31:0] e_paddr; logic e_unc; logic [1:0] e_exc; logic e_miss; logic [3:0] e_idx;
    logic [2:0]  e_strb;
    logic [7:0]  e_asid;
    int          waitc;
    @(negedge clk);
    tlb_wr = 1'b0;
    asid   = 8'($urandom);
    drive_tr(wr_cyc > 0 ? pre : post);
    case (own)
      BI:      begin i_req_valid = 1'b1; i_vaddr = va; end
      BD:      begin d_req_valid = 1'b1; d_vaddr = va; d_is_store = st; end
      default: begin p_req_valid = 1'b1; p_vaddr = va; p_asid = pa; end
    endcase
    e_asid = (own == BP) ? pa : asid;
    #1;
    waitc = 0;
    while (!own_ready(own) && waitc < 20) begin
      @(negedge clk); #1; waitc++;
    end
    n_total++;
    if (own_ready(own) !== 1'b1) begin
      $display("FAIL %s_ready: ready=%b required=1 after %0d cycles", name, own_ready(own), waitc);
      clear_valids();
      return;
    end else n_pass++;
    model_accept(own);
    @(negedge clk);
    clear_valids();
    #1;
    n_total++;
    if ({tlb_vaddr, tlb_asid, p_rsp_valid, d_rsp_valid, i_rsp_valid} !== {va, e_asid, 3'b000}) begin
      $display("FAIL %s_lookup: vaddr=%h asid=%h strobes=%b required vaddr=%h asid=%h strobes=000",
               name, tlb_vaddr, tlb_asid, {p_rsp_valid, d_rsp_valid, i_rsp_valid}, va, e_asid);
    end else n_pass++;
    for (int k = 0; k < wr_cyc; k++) begin
      tlb_wr = 1'b1;
      @(negedge clk); #1;
      n_total++;
      if ({p_rsp_valid, d_rsp_valid, i_rsp_valid} !== 3'b000) begin
        $display("FAIL %s_stall%0d: strobes=%b required=000", name, k, {p_rsp_valid, d_rsp_valid, i_rsp_valid});
      end else n_pass++;
    end
    tlb_wr = 1'b0;
    drive_tr(post);
    model_rsp(own, va, st, post, e_paddr, e_unc, e_exc, e_miss, e_idx);
    e_strb = 3'b001 << own;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      n_total++;
      if ({p_rsp_valid, d_rsp_valid, i_rsp_valid} !== ((c == 0) ? e_strb : 3'b000)) begin
        $display("FAIL %s_strobe%0d: strobes=%b required=%b", name, c,
                 {p_rsp_valid, d_rsp_valid, i_rsp_valid}, (c == 0) ? e_strb : 3'b000);
      end else n_pass++;
      n_total++;
      case (own)
        BI: if (i_rsp_exc !== e_exc || i_rsp_paddr !== e_paddr || (e_exc == 2'd0 && i_rsp_uncached !== e_unc))
              $display("FAIL %s_idata%0d: exc=%0d paddr=%h unc=%b required exc=%0d paddr=%h unc=%b",
                       name, c, i_rsp_exc, i_rsp_paddr, i_rsp_uncached, e_exc, e_paddr, e_unc);
            else n_pass++;
        BD: if (d_rsp_exc !== e_exc || d_rsp_paddr !== e_paddr || (e_exc == 2'd0 && d_rsp_uncached !== e_unc))
              $display("FAIL %s_ddata%0d: exc=%0d paddr=%h unc=%b required exc=%0d paddr=%h unc=%b",
                       name, c, d_rsp_exc, d_rsp_paddr, d_rsp_uncached, e_exc, e_paddr, e_unc);
            else n_pass++;
        default: if (p_rsp_miss !== e_miss || p_rsp_index !== e_idx)
              $display("FAIL %s_pdata%0d: miss=%b index=%0d required miss=%b index=%0d",
                       name, c, p_rsp_miss, p_rsp_index, e_miss, e_idx);
            else n_pass++;
      endcase
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tlb_wr = 1'b0; asid = 8'h00;
    i_req_valid = 1'b1; d_req_valid = 1'b1; p_req_valid = 1'b1;
    i_vaddr = 32'h0; d_vaddr = 32'h0; d_is_store = 1'b0; p_vaddr = 32'h0; p_asid = 8'h0;
    drive_tr(mk_tr(32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0));
    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if ({p_req_ready, d_req_ready, i_req_ready} !== 3'b000)
      $display("FAIL reset_ready: ready=%b required=000", {p_req_ready, d_req_ready, i_req_ready});
    else n_pass++;
    n_total++;
    if ({i_rsp_valid, d_rsp_valid, p_rsp_valid, i_rsp_paddr, d_rsp_paddr, i_rsp_uncached, d_rsp_uncached,
         i_rsp_exc, d_rsp_exc, p_rsp_miss, p_rsp_index, tlb_vaddr, tlb_asid} !== '0)
      $display("FAIL reset_outputs: tlb_vaddr=%h i_paddr=%h d_paddr=%h required all zero",
               tlb_vaddr, i_rsp_paddr, d_rsp_paddr);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = BI;
    tlb_wr = 1'b1;
    #1;
    n_total++;
    if ({p_req_ready, d_req_ready, i_req_ready} !== 3'b000)
      $display("FAIL tlbwr_blocks_ready: ready=%b required=000", {p_req_ready, d_req_ready, i_req_ready});
    else n_pass++;
    tlb_wr = 1'b0;
    #1;
    n_total++;
    if ({p_req_ready, d_req_ready, i_req_ready} !== 3'b100)
      $display("FAIL idle_grant_p: ready=%b required=100", {p_req_ready, d_req_ready, i_req_ready});
    else n_pass++;
    clear_valids();
    i_req_valid = 1'b1;
    #1;
    n_total++;
    if ({p_req_ready, d_req_ready, i_req_ready} !== 3'b001)
      $display("FAIL idle_grant_i: ready=%b required=001", {p_req_ready, d_req_ready, i_req_ready});
    else n_pass++;
    clear_valids();
  endtask

  task automatic test_mapped_fetch();
    run_req(BI, 32'h0040_1234, 1'b0, 8'h00, '0, mk_tr(32'h0123_4234, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3), 0, "fetch_mapped");
    n_total++;
    if ({i_rsp_exc, i_rsp_paddr} !== {2'd0, 32'h0123_4234})
      $display("FAIL fetch_const: exc=%0d paddr=%h required exc=0 paddr=01234234", i_rsp_exc, i_rsp_paddr);
    else n_pass++;
  endtask

  task automatic test_store_dirty();
    run_req(BD, 32'h7FFF_0010, 1'b1, 8'h00, '0, mk_tr(32'h0ABC_0010, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1), 0, "store_clean");
    n_total++;
    if ({d_rsp_exc, d_rsp_paddr} !== {2'd3, 32'h7FFF_0010})
      $display("FAIL store_mod_const: exc=%0d paddr=%h required exc=3 paddr=7fff0010", d_rsp_exc, d_rsp_paddr);
    else n_pass++;
    run_req(BD, 32'h7FFF_0010, 1'b0, 8'h00, '0, mk_tr(32'h0ABC_0010, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1), 0, "load_clean");
    n_total++;
    if ({d_rsp_exc, d_rsp_paddr} !== {2'd0, 32'h0ABC_0010})
      $display("FAIL load_const: exc=%0d paddr=%h required exc=0 paddr=0abc0010", d_rsp_exc, d_rsp_paddr);
    else n_pass++;
  endtask

  task automatic test_kseg1();
    run_req(BD, 32'hA000_1000, 1'b0, 8'h00, '0, mk_tr(32'h0F0F_0F0F, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2), 0, "kseg1_load");
    run_req(BD, 32'hA000_1000, 1'b0, 8'h00, '0, mk_tr(32'h0F0F_0F0F, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2), 0, "kseg1_miss");
    n_total++;
    if ({d_rsp_exc, d_rsp_uncached, d_rsp_paddr} !== {2'd0, 1'b1, 32'h0000_1000})
      $display("FAIL kseg1_const: exc=%0d unc=%b paddr=%h required exc=0 unc=1 paddr=00001000",
               d_rsp_exc, d_rsp_uncached, d_rsp_paddr);
    else n_pass++;
  endtask

  task automatic test_priority();
    int grants[$];
    int gcyc[$];
    int rsps[$];
    bit [2:0] pend;
    logic [2:0] rdy, strb;
    int w;
    int drop;
    drop = -1;
    @(negedge clk);
    tlb_wr = 1'b0;
    drive_tr(mk_tr(32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5));
    i_req_valid = 1'b1; i_vaddr = 32'h8000_0100;
    d_req_valid = 1'b1; d_vaddr = 32'h8000_0200; d_is_store = 1'b0;
    p_req_valid = 1'b1; p_vaddr = 32'h0000_2000; p_asid = 8'h11;
    pend = 3'b111;
    for (int c = 0; c < 30 && rsps.size() < 3; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (drop == BI) i_req_valid = 1'b0;
        if (drop == BD) d_req_valid = 1'b0;
        if (drop == BP) p_req_valid = 1'b0;
        drop = -1;
      end
      #1;
      strb = {p_rsp_valid, d_rsp_valid, i_rsp_valid};
      if (strb == 3'b100) rsps.push_back(BP);
      else if (strb == 3'b010) rsps.push_back(BD);
      else if (strb == 3'b001) rsps.push_back(BI);
      rdy = {p_req_ready, d_req_ready, i_req_ready};
      if (rdy != 3'b000) begin
        w = model_winner(pend[BI], pend[BD], pend[BP]);
        n_total++;
        if (w < 0 || rdy !== (3'b001 << w))
          $display("FAIL prio_grant%0d: ready=%b required winner=%0d", grants.size(), rdy, w);
        else n_pass++;
        if (w >= 0) begin
          pend[w] = 1'b0; drop = w; model_accept(w);
          grants.push_back(w); gcyc.push_back(c);
        end
      end
    end
    clear_valids();
    n_total++;
    if (grants.size() != 3 || rsps.size() != 3 || rsps[0] != grants[0] || rsps[1] != grants[1] || rsps[2] != grants[2])
      $display("FAIL prio_rsp_order: grants=%0d rsps=%0d required 3 responses in grant order", grants.size(), rsps.size());
    else n_pass++;
    n_total++;
    if (gcyc.size() != 3 || gcyc[1] - gcyc[0] != 2 || gcyc[2] - gcyc[1] != 2)
      $display("FAIL back_to_back: grant cycles=%0d entries required spacing 2", gcyc.size());
    else n_pass++;
`ifndef TLB_ARB_RR_EN
    n_total++;
    if (grants.size() != 3 || grants[0] != BP || grants[1] != BD || grants[2] != BI)
      $display("FAIL prio_fixed_order: first=%0d required P,D,I", (grants.size() > 0) ? grants[0] : -1);
    else n_pass++;
`endif
    n_total++;
    if ({i_rsp_paddr, d_rsp_paddr, p_rsp_miss, p_rsp_index} !== {32'h0000_0100, 32'h0000_0200, 1'b0, 4'd5})
      $display("FAIL prio_data: i=%h d=%h miss=%b idx=%0d required i=00000100 d=00000200 miss=0 idx=5",
               i_rsp_paddr, d_rsp_paddr, p_rsp_miss, p_rsp_index);
    else n_pass++;
  endtask

  task automatic test_rr_hold();
    int grants[$];
    logic [2:0] rdy;
    int w;
    int alt_bad;
    alt_bad = 0;
    @(negedge clk);
    tlb_wr = 1'b0;
    i_req_valid = 1'b1; i_vaddr = 32'h8000_0040;
    d_req_valid = 1'b1; d_vaddr = 32'h8000_0080; d_is_store = 1'b0;
    for (int c = 0; c < 20 && grants.size() < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      rdy = {p_req_ready, d_req_ready, i_req_ready};
      if (rdy != 3'b000) begin
        w = model_winner(1'b1, 1'b1, 1'b0);
        n_total++;
        if (rdy !== (3'b001 << w))
          $display("FAIL hold_grant%0d: ready=%b required=%b", grants.size(), rdy, 3'b001 << w);
        else n_pass++;
        model_accept(w);
        grants.push_back(w);
      end
    end
    @(negedge clk);
    clear_valids();
    repeat (3) @(negedge clk);
    for (int k = 1; k < grants.size(); k++) begin
`ifdef TLB_ARB_RR_EN
      if (grants[k] == grants[k-1]) alt_bad++;
`else
      if (grants[k] != BD) alt_bad++;
`endif
    end
    n_total++;
    if (grants.size() != 4 || alt_bad != 0)
      $display("FAIL hold_pattern: grants=%0d bad=%0d required 4 grants, 0 bad", grants.size(), alt_bad);
    else n_pass++;
  endtask

  task automatic test_tlb_wr();
    run_req(BD, 32'h0010_0040, 1'b0, 8'h00, mk_tr(32'hDEAD_0040, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0),
            mk_tr(32'h0555_0040, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2), 2, "tlb_wr_stall");
    n_total++;
    if ({d_rsp_exc, d_rsp_uncached, d_rsp_paddr} !== {2'd0, 1'b1, 32'h0555_0040})
      $display("FAIL tlb_wr_const: exc=%0d unc=%b paddr=%h required exc=0 unc=1 paddr=05550040",
               d_rsp_exc, d_rsp_uncached, d_rsp_paddr);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen;
    int waitc;
    seen = 0;
    @(negedge clk);
    tlb_wr = 1'b0;
    drive_tr(mk_tr(32'h0777_8000, 1'b0, 1'b1, 1'b1, 1'b0, 4'd7));
    i_req_valid = 1'b1; i_vaddr = 32'h0040_8000;
    #1;
    waitc = 0;
    while (!i_req_ready && waitc < 10) begin @(negedge clk); #1; waitc++; end
    @(negedge clk);
    i_req_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    i_req_valid = 1'b1; d_req_valid = 1'b1; p_req_valid = 1'b1;
    #1;
    n_total++;
    if ({p_req_ready, d_req_ready, i_req_ready} !== 3'b000)
      $display("FAIL midreset_ready: ready=%b required=000", {p_req_ready, d_req_ready, i_req_ready});
    else n_pass++;
    n_total++;
    if ({i_rsp_valid, d_rsp_valid, p_rsp_valid, i_rsp_paddr, d_rsp_paddr, i_rsp_uncached, d_rsp_uncached,
         i_rsp_exc, d_rsp_exc, p_rsp_miss, p_rsp_index, tlb_vaddr, tlb_asid} !== '0)
      $display("FAIL midreset_outputs: tlb_vaddr=%h i_paddr=%h d_paddr=%h required all zero",
               tlb_vaddr, i_rsp_paddr, d_rsp_paddr);
    else n_pass++;
    @(negedge clk);
    clear_valids();
    rst_n = 1'b1;
    m_ptr = BI;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if ({p_rsp_valid, d_rsp_valid, i_rsp_valid} != 3'b000) seen++;
    end
    n_total++;
    if (seen != 0) $display("FAIL midreset_no_rsp: strobes seen=%0d required=0", seen);
    else n_pass++;
    run_req(BI, 32'h0040_8000, 1'b0, 8'h00, '0, mk_tr(32'h0777_8000, 1'b0, 1'b1, 1'b1, 1'b0, 4'd7), 0, "after_reset");
  endtask

  task automatic test_random();
    int own;
    logic [31:0] va;
    for (int n = 0; n < 30; n++) begin
      own = $urandom_range(0, 2);
      va  = {3'($urandom_range(0, 7)), 29'($urandom)};
      run_req(own, va, 1'($urandom), 8'($urandom), rand_tr(), rand_tr(), $urandom_range(0, 2), "random");
    end
  endtask

  initial begin
    test_reset();
    test_mapped_fetch();
    test_store_dirty();
    test_kseg1();
    test_priority();
    test_rr_hold();
    test_tlb_wr();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
